// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller.
// MC_BNE_EN adds bne (opcode 000101) as a supported branch.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BOFS = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Successor of DECODE; FETCH here means the opcode is unsupported.
   function automatic state_t decode_next(input logic [5:0] op);
      state_t ns;
      case (op)
         OP_LW, OP_SW: ns = MEMADR;
         OP_RTYPE:     ns = EXECUTE;
         OP_ADDI:      ns = ADDIEX;
         OP_BEQ:       ns = BRANCH;
         OP_J:         ns = JUMP;
`ifdef MC_BNE_EN
         OP_BNE:       ns = BRANCH;
`endif
         default:      ns = FETCH;
      endcase
      return ns;
   endfunction

endpackage

// File: rtl/mc_state_decode.sv
// Combinational map from FSM state (plus last-wait-cycle and bne flags)
// to every datapath control output.
module mc_state_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [3:0] state,
   input  logic       last,
   input  logic       bne_sel,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       IorD,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       ALUSrcA,
   output logic       Branch,
   output logic       BranchNe,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [1:0] ALUOp,
   output logic       instr_done
);

   always_comb begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrcA    = 1'b0;
      Branch     = 1'b0;
      BranchNe   = 1'b0;
      ALUSrcB    = SRCB_REG;
      PCSrc      = PCSRC_ALU;
      ALUOp      = ALUOP_ADD;
      instr_done = 1'b0;
      case (state_t'(state))
         FETCH: begin
            ALUSrcB = SRCB_FOUR;
            IRWrite = last;
            PCWrite = last;
         end
         DECODE: ALUSrcB = SRCB_BOFS;
         MEMADR, ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         MEMRD: IorD = 1'b1;
         MEMWR: begin
            // Only the final wait cycle writes, so a long wait is still one store.
            IorD       = 1'b1;
            MemWrite   = last;
            instr_done = last;
         end
         MEMWB: begin
            RegWrite   = 1'b1;
            MemtoReg   = 1'b1;
            instr_done = 1'b1;
         end
         EXECUTE: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
         end
         ALUWB: begin
            RegWrite   = 1'b1;
            RegDst     = 1'b1;
            instr_done = 1'b1;
         end
         BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUOp      = ALUOP_SUB;
            PCSrc      = PCSRC_ALUOUT;
            Branch     = 1'b1;
            BranchNe   = bne_sel;
            instr_done = 1'b1;
         end
         ADDIWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         JUMP: begin
            PCSrc      = PCSRC_JUMP;
            PCWrite    = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM with MEM_LAT-cycle memory states.
// MC_BNE_EN enables bne through the BRANCH state with BranchNe set.
module multicycle_controller
   import multicycle_ctrl_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       IorD,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       ALUSrcA,
   output logic       Branch,
   output logic       BranchNe,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [1:0] ALUOp,
   output logic       instr_done,
   output logic       illegal
);

   state_t     state, state_next;
   logic [3:0] cnt, cnt_next;
   logic       last;
   logic       bne_q;
   logic [3:0] dec_state;
   logic       dec_last;

   assign last = (cnt == 4'(MEM_LAT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = '0;
      case (state)
         FETCH:   if (last) state_next = DECODE; else cnt_next = cnt + 4'd1;
         DECODE:  state_next = decode_next(opcode);
         MEMADR:  state_next = (opcode == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   if (last) state_next = MEMWB; else cnt_next = cnt + 4'd1;
         MEMWR:   if (last) state_next = FETCH; else cnt_next = cnt + 4'd1;
         EXECUTE: state_next = ALUWB;
         ADDIEX:  state_next = ADDIWB;
         default: state_next = FETCH;
      endcase
   end

`ifdef MC_BNE_EN
   // BRANCH always directly follows DECODE, so a one-cycle flag is enough.
   always_ff @(posedge clk) begin
      if (rst) bne_q <= 1'b0;
      else     bne_q <= (state == DECODE) && (opcode == OP_BNE);
   end
`else
   assign bne_q = 1'b0;
`endif

   // Reset presents the first FETCH cycle regardless of the registered state.
   assign dec_state = rst ? FETCH : state;
   assign dec_last  = rst ? (MEM_LAT == 1) : last;

   assign illegal = !rst && (state == DECODE) && (decode_next(opcode) == FETCH);

   mc_state_decode u_decode (
      .state      (dec_state),
      .last       (dec_last),
      .bne_sel    (bne_q),
      .PCWrite    (PCWrite),
      .IRWrite    (IRWrite),
      .IorD       (IorD),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .RegDst     (RegDst),
      .MemtoReg   (MemtoReg),
      .ALUSrcA    (ALUSrcA),
      .Branch     (Branch),
      .BranchNe   (BranchNe),
      .ALUSrcB    (ALUSrcB),
      .PCSrc      (PCSrc),
      .ALUOp      (ALUOp),
      .instr_done (instr_done)
   );

endmodule
